// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF fetches and MEM loads/stores, one transaction at a time
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_gnt,
  output logic                    i_valid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_busy,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_gnt,
  output logic                    d_valid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_busy,
  output logic                    m_req,
  output logic                    m_we,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_be,
  input  logic                    m_ack,
  input  logic                    m_rvalid,
  input  logic [DATA_WIDTH-1:0]   m_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t                  state_q, state_d;
  logic                    owner_q, owner_d, last_q, last_d;
  logic                    m_req_q, m_req_d, m_we_q, m_we_d;
  logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0]   m_wdata_q, m_wdata_d;
  logic [DATA_WIDTH/8-1:0] m_be_q, m_be_d;
  logic                    idle, sel_d, done;
  // owner/last_grant: 1 = D, 0 = I; a tie goes to whichever side was not granted last
  assign idle    = state_q == IDLE;
  assign sel_d   = d_req & (~i_req | ~last_q);
  assign i_gnt   = idle & i_req & ~sel_d;
  assign d_gnt   = idle & sel_d;
  assign done    = state_q == WAIT & m_rvalid;
  assign i_valid = done & ~owner_q;
  assign d_valid = done & owner_q;
  assign i_rdata = i_valid ? m_rdata : '0;
  assign d_rdata = d_valid ? m_rdata : '0;
  assign i_busy  = i_req | (~idle & ~owner_q);
  assign d_busy  = d_req | (~idle & owner_q);
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_be    = m_be_q;
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_be_d    = m_be_q;
    case (state_q)
      IDLE: if (i_gnt | d_gnt) begin
        state_d   = REQ;
        owner_d   = d_gnt;
        last_d    = d_gnt;
        m_req_d   = 1'b1;
        m_we_d    = d_gnt & d_we;
        m_addr_d  = d_gnt ? d_addr : i_addr;
        m_wdata_d = d_gnt ? d_wdata : '0;
        m_be_d    = d_gnt ? d_be : '1;
      end
      REQ: if (m_ack) begin
        state_d = WAIT;
        m_req_d = 1'b0;
      end
      WAIT: if (m_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_be_q    <= m_be_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, handshakes, field stability and reset abort
module tb_mem_port_arbiter;
  logic        clk = 0, reset = 1;
  logic        i_req = 0, i_gnt, i_valid, i_busy;
  logic [31:0] i_addr = 0, i_rdata;
  logic        d_req = 0, d_we = 0, d_gnt, d_valid, d_busy;
  logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
  logic [3:0]  d_be = 0, m_be;
  logic        m_req, m_we, m_ack = 0, m_rvalid = 0;
  logic [31:0] m_addr, m_wdata, m_rdata = 0;
  int errors = 0, checks = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata), .i_busy(i_busy),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_busy(d_busy),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1;
    cyc();
    reset = 0;
  endtask

  task automatic test_reset();
    cyc();
    checks++; if (m_req !== 0) begin errors++; $display("FAIL reset_m_req: got %b want 0", m_req); end
    checks++; if ({m_we, m_addr, m_wdata, m_be} !== '0) begin errors++; $display("FAIL reset_m_fields: got %h want 0", {m_we, m_addr, m_wdata, m_be}); end
    checks++; if ({i_gnt, d_gnt, i_valid, d_valid, i_busy, d_busy} !== 6'b0) begin errors++; $display("FAIL reset_outs: got %b want 000000", {i_gnt, d_gnt, i_valid, d_valid, i_busy, d_busy}); end
    checks++; if ({i_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", {i_rdata, d_rdata}); end
    reset = 0;
  endtask

  task automatic test_fetch();
    @(negedge clk); i_req = 1; i_addr = 32'h100; #1;
    checks++; if ({i_gnt, d_gnt} !== 2'b10) begin errors++; $display("FAIL fetch_gnt: got %b want 10", {i_gnt, d_gnt}); end
    @(negedge clk); i_req = 0; m_ack = 1; #1;
    checks++; if ({m_req, m_we, m_addr, m_wdata, m_be} !== {1'b1, 1'b0, 32'h100, 32'h0, 4'hF}) begin errors++; $display("FAIL fetch_mfields: got %h want %h", {m_req, m_we, m_addr, m_wdata, m_be}, {1'b1, 1'b0, 32'h100, 32'h0, 4'hF}); end
    checks++; if (i_busy !== 1) begin errors++; $display("FAIL fetch_busy: got %b want 1", i_busy); end
    @(negedge clk); m_ack = 0; m_rvalid = 1; m_rdata = 32'h00500093; #1;
    checks++; if ({m_req, i_valid, d_valid} !== 3'b010) begin errors++; $display("FAIL fetch_valid: got %b want 010", {m_req, i_valid, d_valid}); end
    checks++; if (i_rdata !== 32'h00500093) begin errors++; $display("FAIL fetch_rdata: got %h want 00500093", i_rdata); end
    @(negedge clk); m_rvalid = 0; m_rdata = 0; #1;
    checks++; if ({i_valid, i_busy, i_rdata} !== 34'h0) begin errors++; $display("FAIL fetch_idle: got %h want 0", {i_valid, i_busy, i_rdata}); end
  endtask

  task automatic test_store();
    @(negedge clk); d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011; #1;
    checks++; if ({i_gnt, d_gnt} !== 2'b01) begin errors++; $display("FAIL store_gnt: got %b want 01", {i_gnt, d_gnt}); end
    @(negedge clk); d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({m_req, m_we, m_addr, m_wdata, m_be} !== {1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011}) begin errors++; $display("FAIL store_hold%0d: got %h want %h", k, {m_req, m_we, m_addr, m_wdata, m_be}, {1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011}); end
      @(negedge clk);
    end
    m_ack = 1;
    @(negedge clk); m_ack = 0; m_rvalid = 1; m_rdata = 0; #1;
    checks++; if ({m_req, i_valid, d_valid, d_busy} !== 4'b0011) begin errors++; $display("FAIL store_valid: got %b want 0011", {m_req, i_valid, d_valid, d_busy}); end
    checks++; if (d_rdata !== 0) begin errors++; $display("FAIL store_rdata: got %h want 0", d_rdata); end
    @(negedge clk); m_rvalid = 0; #1;
    checks++; if ({d_valid, d_busy} !== 2'b00) begin errors++; $display("FAIL store_idle: got %b want 00", {d_valid, d_busy}); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_gnt;
    logic [31:0] exp_addr;
    pulse_reset();
    i_req = 1; i_addr = 32'h400; d_req = 1; d_we = 0; d_addr = 32'h8000; d_be = 4'hF;
    for (int k = 0; k < 4; k++) begin
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (k % 2 == 0) ? 32'h8000 : 32'h400;
      #1;
      checks++; if ({i_gnt, d_gnt} !== exp_gnt) begin errors++; $display("FAIL cont_gnt%0d: got %b want %b", k, {i_gnt, d_gnt}, exp_gnt); end
      @(negedge clk); m_ack = 1; #1;
      checks++; if ({m_req, m_addr, i_busy, d_busy, i_gnt, d_gnt} !== {1'b1, exp_addr, 4'b1100}) begin errors++; $display("FAIL cont_req%0d: got %h want %h", k, {m_req, m_addr, i_busy, d_busy, i_gnt, d_gnt}, {1'b1, exp_addr, 4'b1100}); end
      @(negedge clk); m_ack = 0; m_rvalid = 1; m_rdata = exp_addr + 1; #1;
      checks++; if ({m_req, i_valid, d_valid} !== {1'b0, exp_gnt}) begin errors++; $display("FAIL cont_valid%0d: got %b want %b", k, {m_req, i_valid, d_valid}, {1'b0, exp_gnt}); end
      @(negedge clk); m_rvalid = 0; m_rdata = 0;
    end
    i_req = 0; d_req = 0;
  endtask

  task automatic test_stability();
    @(negedge clk); d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'h12345678; d_be = 4'b1100; #1;
    checks++; if (d_gnt !== 1) begin errors++; $display("FAIL stab_gnt: got %b want 1", d_gnt); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); d_addr = 32'h5000 + k; d_wdata = ~d_wdata; d_be = 4'(k); d_we = k[0]; i_req = ~k[0]; i_addr = 32'h700 + k; #1;
      checks++; if ({m_req, m_we, m_addr, m_wdata, m_be, i_gnt, d_gnt} !== {1'b1, 1'b1, 32'h3000, 32'h12345678, 4'b1100, 2'b00}) begin errors++; $display("FAIL stab_hold%0d: got %h want %h", k, {m_req, m_we, m_addr, m_wdata, m_be, i_gnt, d_gnt}, {1'b1, 1'b1, 32'h3000, 32'h12345678, 4'b1100, 2'b00}); end
    end
    d_req = 0; i_req = 0; m_ack = 1;
    @(negedge clk); m_ack = 0; m_rvalid = 1;
    @(negedge clk); m_rvalid = 0;
  endtask

  task automatic test_spurious();
    @(negedge clk); m_rvalid = 1; #1;
    checks++; if ({i_valid, d_valid} !== 2'b00) begin errors++; $display("FAIL spur_idle_valid: got %b want 00", {i_valid, d_valid}); end
    @(negedge clk); m_rvalid = 0; #1;
    checks++; if ({m_req, i_busy, d_busy} !== 3'b000) begin errors++; $display("FAIL spur_idle_state: got %b want 000", {m_req, i_busy, d_busy}); end
    i_req = 1; i_addr = 32'h900;
    @(negedge clk); i_req = 0; m_rvalid = 1; #1;
    checks++; if ({i_valid, d_valid} !== 2'b00) begin errors++; $display("FAIL spur_req_valid: got %b want 00", {i_valid, d_valid}); end
    @(negedge clk); m_rvalid = 0; #1;
    checks++; if (m_req !== 1) begin errors++; $display("FAIL spur_req_state: got %b want 1", m_req); end
    m_ack = 1;
    @(negedge clk); #1;
    checks++; if ({m_req, i_valid, i_busy} !== 3'b001) begin errors++; $display("FAIL spur_wait_ack: got %b want 001", {m_req, i_valid, i_busy}); end
    @(negedge clk); m_ack = 0; #1;
    checks++; if ({m_req, i_busy, i_gnt} !== 3'b010) begin errors++; $display("FAIL spur_wait_state: got %b want 010", {m_req, i_busy, i_gnt}); end
    m_rvalid = 1; m_rdata = 32'hCAFE0001; #1;
    checks++; if ({i_valid, i_rdata} !== {1'b1, 32'hCAFE0001}) begin errors++; $display("FAIL spur_wait_done: got %h want %h", {i_valid, i_rdata}, {1'b1, 32'hCAFE0001}); end
    @(negedge clk); m_rvalid = 0; m_rdata = 0;
  endtask

  task automatic test_reset_wait();
    @(negedge clk); i_req = 1; i_addr = 32'hA00;
    @(negedge clk); i_req = 0; m_ack = 1;
    @(negedge clk); m_ack = 0; reset = 1; #1;
    checks++; if ({m_req, i_busy, i_valid} !== 3'b000) begin errors++; $display("FAIL rst_wait_abort: got %b want 000", {m_req, i_busy, i_valid}); end
    @(negedge clk); reset = 0;
    @(negedge clk);
    @(negedge clk); m_rvalid = 1; m_rdata = 32'hBAD; #1;
    checks++; if ({i_valid, d_valid, m_req, i_rdata} !== 35'h0) begin errors++; $display("FAIL rst_late_rvalid: got %h want 0", {i_valid, d_valid, m_req, i_rdata}); end
    @(negedge clk); m_rvalid = 0; m_rdata = 0; i_req = 1; d_req = 1; d_we = 0; d_addr = 32'hB00; #1;
    checks++; if ({i_gnt, d_gnt} !== 2'b01) begin errors++; $display("FAIL rst_tie: got %b want 01", {i_gnt, d_gnt}); end
    @(negedge clk); d_req = 0; i_req = 0; m_ack = 1;
    @(negedge clk); m_ack = 0; m_rvalid = 1; #1;
    checks++; if ({i_valid, d_valid} !== 2'b01) begin errors++; $display("FAIL rst_tie_done: got %b want 01", {i_valid, d_valid}); end
    @(negedge clk); m_rvalid = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_stability();
    test_spurious();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
